bias_add_stream: RTL

- Streaming per-channel bias adder for convolution layer outputs.
- Holds a run-time-loadable table of CHANNELS sign-magnitude biases, replacing fixed per-layer bias constants.
- Adds the current channel's bias to each incoming two's-complement accumulator beat, saturates, and forwards the result under valid/ready flow control.
- Sits between a layer's MAC array output and the next layer's input buffer.

---
 rtl/bias_add_stream_if.sv | 27 ++
 rtl/bias_add_stream.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bias_add_stream_if.sv
// Stream-side bundle for bias_add_stream: accumulator input beats and biased output beats.
// slave faces the bias adder, master faces the producer/consumer driving it.
interface bias_add_stream_if #(
    parameter int IN_W   = 16,
    parameter int CHAN_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_first;
    logic              out_valid;
    logic              out_ready;
    logic [IN_W-1:0]   out_data;
    logic [CHAN_W-1:0] out_chan;
    logic              out_last;
    logic              out_sat;

    modport slave (
        input  in_valid, in_data, in_first, out_ready,
        output in_ready, out_valid, out_data, out_chan, out_last, out_sat
    );

    modport master (
        output in_valid, in_data, in_first, out_ready,
        input  in_ready, out_valid, out_data, out_chan, out_last, out_sat
    );
endinterface

// File: rtl/bias_add_stream.sv
// Two-stage streaming per-channel bias adder with a run-time bias table and output saturation.
// Optional ReLU after saturation is enabled by defining BIAS_ADD_RELU_EN.
module bias_add_stream #(
    parameter int IN_W       = 16,
    parameter int BIAS_W     = 16,
    parameter int CHANNELS   = 64,
    parameter int BIAS_SHIFT = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_we,
    input  logic [$clog2(CHANNELS)-1:0] cfg_addr,
    input  logic [BIAS_W-1:0]           cfg_data,
    bias_add_stream_if.slave            bus
);

    localparam int CHAN_W = $clog2(CHANNELS);
    // Shifted bias needs BIAS_W-1+BIAS_SHIFT magnitude bits plus a sign bit.
    localparam int SB_W   = BIAS_W + BIAS_SHIFT;
    localparam int SUM_W  = ((IN_W > SB_W) ? IN_W : SB_W) + 1;

    localparam logic [CHAN_W-1:0]       LAST_CH  = CHAN_W'(CHANNELS - 1);
    localparam logic [CHAN_W:0]         CHAN_LIM = (CHAN_W + 1)'(CHANNELS);
    localparam logic [SB_W-1:0]         SB_ONE   = SB_W'(1);
    localparam logic [CHAN_W-1:0]       CH_ONE   = CHAN_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_MAX  = {{(SUM_W - IN_W + 1){1'b0}}, {(IN_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN  = {{(SUM_W - IN_W + 1){1'b1}}, {(IN_W - 1){1'b0}}};

    // Sign-magnitude to two's complement; a negative zero naturally maps to 0.
    function automatic logic signed [SB_W-1:0] bias_to_twos(input logic [BIAS_W-1:0] raw);
        logic [SB_W-1:0] mag;
        mag = '0;
        mag[BIAS_W-2+BIAS_SHIFT:BIAS_SHIFT] = raw[BIAS_W-2:0];
        if (raw[BIAS_W-1]) begin
            return $signed(~mag + SB_ONE);
        end else begin
            return $signed(mag);
        end
    endfunction

    logic [BIAS_W-1:0]       bias_tab_r [CHANNELS];
    logic [CHAN_W-1:0]       cnt_r;

    logic                    s1_valid_r;
    logic [IN_W-1:0]         s1_data_r;
    logic [CHAN_W-1:0]       s1_chan_r;
    logic signed [SB_W-1:0]  s1_bias_r;

    logic                    s2_valid_r;
    logic [IN_W-1:0]         s2_data_r;
    logic [CHAN_W-1:0]       s2_chan_r;
    logic                    s2_last_r;
    logic                    s2_sat_r;

    logic                    s2_adv_s;
    logic                    in_ready_s;
    logic                    in_fire_s;
    logic                    cfg_hit_s;
    logic [CHAN_W-1:0]       in_chan_s;
    logic [CHAN_W-1:0]       next_cnt_s;
    logic signed [SUM_W-1:0] sum_s;
    logic [IN_W-1:0]         res_data_s;
    logic                    res_sat_s;

    // Handshake: a stage advances when empty or when its downstream advances.
    always_comb begin
        s2_adv_s   = !s2_valid_r || bus.out_ready;
        in_ready_s = !s1_valid_r || s2_adv_s;
        in_fire_s  = bus.in_valid && in_ready_s;
        cfg_hit_s  = cfg_we && ({1'b0, cfg_addr} < CHAN_LIM);
    end

    // Channel of the incoming beat and the counter value that follows it.
    always_comb begin
        if (bus.in_first) begin
            in_chan_s = '0;
        end else begin
            in_chan_s = cnt_r;
        end
        if (in_chan_s == LAST_CH) begin
            next_cnt_s = '0;
        end else begin
            next_cnt_s = in_chan_s + CH_ONE;
        end
    end

    // Bias table; a write lands at the edge, so a beat entering S1 on that edge reads the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                bias_tab_r[i] <= '0;
            end
        end else if (cfg_hit_s) begin
            bias_tab_r[cfg_addr] <= cfg_data;
        end
    end

    // Channel counter advances on every accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (in_fire_s) begin
            cnt_r <= next_cnt_s;
        end
    end

    // Stage 1: capture the beat, its channel and the converted bias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_chan_r  <= '0;
            s1_bias_r  <= '0;
        end else if (in_ready_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data_r <= bus.in_data;
                s1_chan_r <= in_chan_s;
                s1_bias_r <= bias_to_twos(bias_tab_r[in_chan_s]);
            end
        end
    end

    // Stage 2 datapath: widened add, clamp to the IN_W signed range, optional ReLU.
    always_comb begin
        sum_s = {{(SUM_W - IN_W){s1_data_r[IN_W-1]}}, s1_data_r}
              + {{(SUM_W - SB_W){s1_bias_r[SB_W-1]}}, s1_bias_r};
        if (sum_s > SAT_MAX) begin
            res_data_s = SAT_MAX[IN_W-1:0];
            res_sat_s  = 1'b1;
        end else if (sum_s < SAT_MIN) begin
            res_data_s = SAT_MIN[IN_W-1:0];
            res_sat_s  = 1'b1;
        end else begin
            res_data_s = sum_s[IN_W-1:0];
            res_sat_s  = 1'b0;
        end
`ifdef BIAS_ADD_RELU_EN
        if (res_data_s[IN_W-1]) begin
            res_data_s = '0;
        end else begin
            res_data_s = res_data_s;
        end
`endif
    end

    // Stage 2 registers drive the outputs directly, so they hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_data_r  <= '0;
            s2_chan_r  <= '0;
            s2_last_r  <= 1'b0;
            s2_sat_r   <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_data_r <= res_data_s;
                s2_chan_r <= s1_chan_r;
                s2_last_r <= (s1_chan_r == LAST_CH);
                s2_sat_r  <= res_sat_s;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.out_data  = s2_data_r;
    assign bus.out_chan  = s2_chan_r;
    assign bus.out_last  = s2_last_r;
    assign bus.out_sat   = s2_sat_r;

endmodule
